// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: default transfer width and bit-counter sizing.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    // Counter must index 0..DATA_WIDTH-1; keep at least one bit for degenerate widths.
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int SPI_CNT_W = cnt_width(SPI_DATA_WIDTH);

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin, plus a delayed copy that yields
// single-cycle rise/fall strobes in the clk domain.
module sync_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: shifts MOSI bytes in MSB-first on SCLK rise, echoes the previous
// byte on MISO on SCLK fall. All pins are oversampled by clk.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] received_data
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s1_q, mosi_s2_q;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  miso_q, miso_d;

    sync_edge_detect #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    // cs idles high, so its synchronizer resets high to avoid a false frame start.
    sync_edge_detect #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d_i(cs),
        .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_comb begin
        cnt_d  = cnt_q;
        rx_d   = rx_q;
        tx_d   = tx_q;
        data_d = data_q;
        done_d = done_q;
        miso_d = miso_q;
        if (cs_fall) begin
            cnt_d  = '0;
            done_d = 1'b0;
            tx_d   = data_q;
            miso_d = data_q[DATA_WIDTH-1];
        end else if (cs_s) begin
            // Deselected: drop any partial byte, hold results, park MISO low.
            miso_d = 1'b0;
            if (cs_rise) begin
                cnt_d = '0;
                rx_d  = '0;
            end
        end else begin
            if (sclk_rise) begin
                rx_d = {rx_q[DATA_WIDTH-2:0], mosi_s2_q};
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d  = '0;
                    data_d = rx_d;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (sclk_fall) begin
                tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                miso_d = tx_q[DATA_WIDTH-2];
            end
        end
    end

    // mosi gets the same two-flop depth so it lines up with the sclk strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            data_q    <= data_d;
            done_q    <= done_d;
            miso_q    <= miso_d;
        end
    end

    assign miso          = miso_q;
    assign done          = done_q;
    assign received_data = data_q;

    logic unused_sclk_s;
    assign unused_sclk_s = sclk_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a master model drives SPI pins, expected bytes go
// into a scoreboard that a monitor drains whenever received_data changes.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, cs, mosi;
    logic       miso, done;
    logic [7:0] received_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    spi_slave #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .done(done), .received_data(received_data)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        wait_clk(4);
    endtask

    // One SCLK period of 8 clk cycles; MISO is sampled just before the rise.
    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        wait_clk(4);
        m    = miso;
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit chk_done, output logic [7:0] rd);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) sb.push_back(v);
            send_bit(v[i], m);
            rd[i] = m;
            if (chk_done) check("done_held_multibyte", done, 1);
        end
    endtask

    // Monitor: every change of received_data outside reset must match the next expected byte.
    initial begin : monitor
        logic [7:0] prev;
        logic [7:0] e;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 8'h00;
            end else if (received_data !== prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", received_data);
                end else begin
                    e = sb.pop_front();
                    check("rx_byte", received_data, e);
                    check("done_with_byte", done, 1);
                end
                prev = received_data;
            end
        end
    end

    initial begin : stim
        logic [7:0] rd;
        logic       m;
        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #15;
        check("rst_data", received_data, 8'h00);
        check("rst_done", done, 0);
        check("rst_miso", miso, 0);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(4);
        check("idle_data", received_data, 8'h00);
        check("idle_done", done, 0);
        check("idle_miso", miso, 0);

        // Frame 1: 0x3C
        cs_low();
        send_byte(8'h3C, 1'b0, rd);
        wait_clk(5);
        check("f1_done", done, 1);
        check("f1_data", received_data, 8'h3C);
        cs_high();
        check("f1_done_after_cs", done, 1);
        check("f1_data_after_cs", received_data, 8'h3C);
        check("miso_idle_low", miso, 0);

        // Frame 2: 0xA5 in, previous byte 0x3C echoed on MISO
        cs_low();
        check("f2_done_cleared", done, 0);
        send_byte(8'hA5, 1'b0, rd);
        check("f2_miso_echo", rd, 8'h3C);
        wait_clk(5);
        cs_high();
        check("f2_done", done, 1);
        check("f2_data", received_data, 8'hA5);

        // Frame 3: two bytes under one cs
        cs_low();
        send_byte(8'h12, 1'b0, rd);
        check("f3_miso_echo", rd, 8'hA5);
        wait_clk(5);
        check("f3_byte1_done", done, 1);
        check("f3_byte1_data", received_data, 8'h12);
        send_byte(8'h34, 1'b1, rd);
        wait_clk(5);
        cs_high();
        check("f3_byte2_data", received_data, 8'h34);

        // Aborted frame: 5 bits of 0xFF then cs high
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'b1, m);
        cs_high();
        check("abort_data", received_data, 8'h34);
        check("abort_done", done, 0);
        cs_low();
        send_byte(8'h81, 1'b0, rd);
        check("after_abort_miso", rd, 8'h34);
        wait_clk(5);
        cs_high();
        check("after_abort_data", received_data, 8'h81);
        check("after_abort_done", done, 1);

        // Async reset after 4 bits
        cs_low();
        for (int i = 0; i < 4; i++) send_bit(1'b1, m);
        #5;
        rst = 1'b0;
        #1;
        check("async_rst_data", received_data, 8'h00);
        check("async_rst_done", done, 0);
        check("async_rst_miso", miso, 0);
        cs = 1'b1; sclk = 1'b0;
        wait_clk(2);
        rst = 1'b1;
        wait_clk(4);
        cs_low();
        send_byte(8'h55, 1'b0, rd);
        check("post_rst_miso", rd, 8'h00);
        wait_clk(5);
        cs_high();
        check("post_rst_data", received_data, 8'h55);
        check("post_rst_done", done, 1);

        wait_clk(2);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
